// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: op codes, FSM states, read selects.
// MADD/MADDU encodings are only decoded when MULT_ACC_EN is defined.
package mult_hilo_ctrl_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;
    localparam logic [1:0] OP_MADD  = 2'd2;
    localparam logic [1:0] OP_MADDU = 2'd3;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    // Wide enough for LAT-1 with LAT up to 15.
    localparam int unsigned CntW = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Request handshake and HI/LO read port between the execute stage (master) and the
// multiply sequencer (slave).
interface mult_hilo_ctrl_if #(
    parameter int unsigned N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [N-1:0] req_x;
    logic [N-1:0] req_y;
    logic         rd_sel;
    logic         rd_req;
    logic [N-1:0] rd_data;
    logic         stall;

    modport master (
        output req_valid, req_op, req_x, req_y, rd_sel, rd_req,
        input  req_ready, rd_data, stall
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, rd_sel, rd_req,
        output req_ready, rd_data, stall
    );
endinterface

// File: rtl/mult_hilo_ctrl_mult.sv
// Combinational N x N multiplier; signed or unsigned by a flag, full 2N-bit product.
// Timed as a LAT-cycle multicycle path from the sequencer's operand registers.
module mult_hilo_ctrl_mult #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           sgn,
    output logic [2*N-1:0] prod
);
    logic [2*N-1:0] x_ext;
    logic [2*N-1:0] y_ext;

    // Low 2N bits of a 2N x 2N product equal the signed product when both are sign-extended.
    assign x_ext = {{N{sgn & x[N-1]}}, x};
    assign y_ext = {{N{sgn & y[N-1]}}, y};
    assign prod  = x_ext * y_ext;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Multi-cycle HI/LO multiply sequencer: holds operands for LAT cycles, commits to HI/LO.
// Optional feature macro: MULT_ACC_EN (ops 2/3 become MADD/MADDU accumulating into HI/LO).
module mult_hilo_ctrl
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_hilo_ctrl_if.slave   bus,
    input  logic              flush,
    output logic              busy,
    output logic              ov
);
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [N-1:0]    x_q, y_q;
    logic            sgn_q, ov_q, ov_d;
    logic            accept, op_ld;
    logic [2*N-1:0]  prod, res;
    logic            res_ov, mul_ov;

    mult_hilo_ctrl_mult #(
        .N(N)
    ) u_mult (
        .x   (x_q),
        .y   (y_q),
        .sgn (sgn_q),
        .prod(prod)
    );

    assign mul_ov = sgn_q ? (prod[2*N-1:N] != {N{prod[N-1]}}) : (|prod[2*N-1:N]);

`ifdef MULT_ACC_EN
    logic         acc_q;
    logic [2*N:0] sum;

    assign sum = {1'b0, hi_q, lo_q} + {1'b0, prod};
    assign res = acc_q ? sum[2*N-1:0] : prod;
    // Signed add overflows when like-signed operands give an unlike-signed sum.
    assign res_ov = !acc_q ? mul_ov :
                    sgn_q  ? ((hi_q[N-1] == prod[2*N-1]) && (sum[2*N-1] != hi_q[N-1])) :
                             sum[2*N];
`else
    assign res    = prod;
    assign res_ov = mul_ov;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ov_d    = ov_q;
        op_ld   = 1'b0;
        accept  = bus.req_valid && (state_q == StIdle) && !flush;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef MULT_ACC_EN
                    op_ld   = 1'b1;
                    cnt_d   = CntW'(LAT - 1);
                    state_d = StBusy;
`else
                    unique case (bus.req_op)
                        OP_MTHI: hi_d = bus.req_x;
                        OP_MTLO: lo_d = bus.req_x;
                        default: begin
                            op_ld   = 1'b1;
                            cnt_d   = CntW'(LAT - 1);
                            state_d = StBusy;
                        end
                    endcase
`endif
                end
            end
            StBusy: begin
                // Flush beats a same-edge commit.
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = res;
                    ov_d         = res_ov;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ov_q    <= ov_d;
        end
    end

    // Operands load only on accept so the multiplier inputs stay put through BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            sgn_q <= 1'b0;
`ifdef MULT_ACC_EN
            acc_q <= 1'b0;
`endif
        end else if (op_ld) begin
            x_q   <= bus.req_x;
            y_q   <= bus.req_y;
            sgn_q <= !bus.req_op[0];
`ifdef MULT_ACC_EN
            acc_q <= bus.req_op[1];
`endif
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign busy          = (state_q == StBusy);
    assign bus.stall     = bus.rd_req && busy;
    assign bus.rd_data   = (bus.rd_sel == SEL_HI) ? hi_q : lo_q;
    assign ov            = ov_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed, table-driven bench for mult_hilo_ctrl (N=32, LAT=3, default build).
module tb_mult_hilo_ctrl;
    import mult_hilo_ctrl_pkg::*;

    localparam int unsigned N   = 32;
    localparam int unsigned LAT = 3;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
    logic ov;

    int n_tests = 0;
    int n_fail  = 0;

    mult_hilo_ctrl_if #(.N(N)) bus ();

    mult_hilo_ctrl #(
        .N  (N),
        .LAT(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .flush(flush),
        .busy (busy),
        .ov   (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.rd_sel = SEL_HI;
        #1 hi = bus.rd_data;
        bus.rd_sel = SEL_LO;
        #1 lo = bus.rd_data;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue: req_ready got %b expected 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        step();
        bus.req_valid = 1'b0;
    endtask

    logic [31:0] hi, lo;

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b1};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1};
        vecs[3] = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 1'b1};
        vecs[4] = '{OP_MTLO,  32'h0000ABCD, 32'h0,        32'h12345678, 32'h0000ABCD, 1'b1};
        vecs[5] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1};
        vecs[6] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0};
        vecs[7] = '{OP_MULTU, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        vecs[8] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_MULT;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rd_sel    = SEL_LO;
        bus.rd_req    = 1'b0;

        #2;
        read_hilo(hi, lo);
        check("reset ready", 32'(bus.req_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset ov", 32'(ov), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].x, vecs[i].y);
            wait_idle($sformatf("vec%0d wait", i));
            read_hilo(hi, lo);
            check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            check($sformatf("vec%0d ov", i), 32'(ov), 32'(vecs[i].ov));
        end

        // Async reset while a multiply is in flight.
        issue(OP_MULT, 32'd7, 32'd7);
        check("midrst busy before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        read_hilo(hi, lo);
        check("midrst ready", 32'(bus.req_ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst hi", hi, 32'h0);
        check("midrst lo", lo, 32'h0);
        check("midrst ov", 32'(ov), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Latency and read stall: MFHI held during the whole BUSY window.
        bus.rd_req = 1'b1;
        bus.rd_sel = SEL_HI;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        for (int c = 0; c < LAT; c++) begin
            check($sformatf("lat busy c%0d", c), 32'(busy), 32'd1);
            check($sformatf("lat stall c%0d", c), 32'(bus.stall), 32'd1);
            check($sformatf("lat ready c%0d", c), 32'(bus.req_ready), 32'd0);
            step();
        end
        check("lat busy done", 32'(busy), 32'd0);
        check("lat stall done", 32'(bus.stall), 32'd0);
        check("lat ready done", 32'(bus.req_ready), 32'd1);
        check("lat mfhi retry", bus.rd_data, 32'hFFFFFFFF);
        bus.rd_req = 1'b0;

        // Flush on the last BUSY cycle suppresses the commit.
        issue(OP_MULT, 32'd5, 32'd7);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        read_hilo(hi, lo);
        check("flush busy", 32'(busy), 32'd0);
        check("flush ready", 32'(bus.req_ready), 32'd1);
        check("flush hi", hi, 32'hFFFFFFFF);
        check("flush lo", lo, 32'hFFFFFFFA);
        check("flush ov", 32'(ov), 32'd0);

        // MTLO then MULT on the very next edge.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MTLO;
        bus.req_x     = 32'd1234;
        step();
        bus.rd_sel = SEL_LO;
        #1;
        check("b2b mtlo lo", bus.rd_data, 32'd1234);
        check("b2b ready", 32'(bus.req_ready), 32'd1);
        bus.req_op = OP_MULT;
        bus.req_x  = 32'd2;
        bus.req_y  = 32'd2;
        step();
        bus.req_valid = 1'b0;
        check("b2b busy", 32'(busy), 32'd1);
        wait_idle("b2b wait");
        read_hilo(hi, lo);
        check("b2b hi", hi, 32'h0);
        check("b2b lo", lo, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
